// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the program counter, reads
//             instruction memory over a req/ack handshake and hands
//             instr_f / increPC_f / nop_D to decode. A one-entry skid
//             buffer absorbs an instruction that returns while decode is
//             stalled; redirects squash in-flight fetches.
//  Ports    : clk, rst (async, active-high)
//             stall_f                       - decode back-pressure
//             redirect_valid, redirect_pc   - taken jmp/branch target
//             imem_req, imem_addr           - read request (registered)
//             imem_ack, imem_rdata          - read completion / data
//             instr_f, increPC_f, nop_D     - outputs to decode
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int             INSTR_W  = 24,
    parameter int             PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_f,
    output logic [PC_W-1:0]    increPC_f,
    output logic               nop_D
);

    localparam logic [PC_W-1:0] c_one = PC_W'(1);

    // FETCH : request outstanding at r_pc
    // HELD  : skid buffer full, no request issued
    // FLUSH : stale request outstanding, its data will be thrown away
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HELD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_addr;
    logic                 r_req;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_incr;
    logic                 r_nop;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [PC_W-1:0]      r_skid_incr;

    logic                 w_ack;
    logic [PC_W-1:0]      w_pc_inc;

    // An ack only counts against a request that is actually on the bus.
    assign w_ack    = imem_ack & r_req;
    assign w_pc_inc = r_pc + c_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_req        <= 1'b0;
            r_instr      <= '0;
            r_incr       <= '0;
            r_nop        <= 1'b1;
            r_skid_instr <= '0;
            r_skid_incr  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect_valid) begin
                        r_nop <= 1'b1;
                        r_pc  <= redirect_pc;
                        r_req <= 1'b1;
                        if (r_req && !w_ack) begin
                            // Request still pending: address must stay put
                            // until memory answers, then that data is dropped.
                            r_state <= S_FLUSH;
                        end else begin
                            r_addr <= redirect_pc;
                        end
                    end else if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (stall_f) begin
                            r_skid_instr <= imem_rdata;
                            r_skid_incr  <= w_pc_inc;
                            r_req        <= 1'b0;
                            r_state      <= S_HELD;
                        end else begin
                            r_instr <= imem_rdata;
                            r_incr  <= w_pc_inc;
                            r_nop   <= 1'b0;
                            r_addr  <= w_pc_inc;
                            r_req   <= 1'b1;
                        end
                    end else begin
                        // No completion: keep (or start) the request at pc.
                        r_req  <= 1'b1;
                        r_addr <= r_pc;
                        if (!stall_f) begin
                            r_nop <= 1'b1;
                        end
                    end
                end

                S_HELD: begin
                    if (redirect_valid) begin
                        r_nop   <= 1'b1;
                        r_pc    <= redirect_pc;
                        r_addr  <= redirect_pc;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (!stall_f) begin
                        // Present the buffered word and restart fetching
                        // at the already-advanced pc in the same edge.
                        r_instr <= r_skid_instr;
                        r_incr  <= r_skid_incr;
                        r_nop   <= 1'b0;
                        r_addr  <= r_pc;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end

                S_FLUSH: begin
                    r_nop <= 1'b1;
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (w_ack) begin
                        r_addr  <= redirect_valid ? redirect_pc : r_pc;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_FETCH;
                    r_nop   <= 1'b1;
                    r_addr  <= r_pc;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign instr_f   = r_instr;
    assign increPC_f = r_incr;
    assign nop_D     = r_nop;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. Memory returns
//             an address-tagged word; each scenario task drives stimulus and
//             compares the packed output bundle against hand-derived values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int INSTR_W = 24;
    localparam int PC_W    = 8;
    localparam int OBS_W   = 1 + PC_W + INSTR_W + PC_W + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall_f;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_f;
    logic [PC_W-1:0]    increPC_f;
    logic               nop_D;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_f        (instr_f),
        .increPC_f      (increPC_f),
        .nop_D          (nop_D)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] tag(input logic [PC_W-1:0] a);
        return {16'hA500, a};
    endfunction

    // Memory word is a pure function of the address being requested.
    assign imem_rdata = tag(imem_addr);

    logic [OBS_W-1:0] obs;
    assign obs = {imem_req, imem_addr, instr_f, increPC_f, nop_D};

    function automatic logic [OBS_W-1:0] exp_obs(input logic req, input logic [PC_W-1:0] addr,
                                                 input logic [INSTR_W-1:0] ins,
                                                 input logic [PC_W-1:0] inc, input logic nop);
        return {req, addr, ins, inc, nop};
    endfunction

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        logic [OBS_W-1:0] e;
        rst = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 8'h33; imem_ack = 1'b1;
        step();
        e = exp_obs(1'b0, 8'h00, '0, 8'h00, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_values got=%h want=%h", obs, e);
        end
        step();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_hold got=%h want=%h", obs, e);
        end
        rst = 1'b0;
        imem_ack = 1'b0;
    endtask

    // ------------------------------------------- zero-wait stream with wrap
    task automatic test_zero_wait();
        logic [OBS_W-1:0] e;
        logic [PC_W-1:0]  kk;
        do_reset();
        imem_ack = 1'b1;
        step();  // request goes up; ack while req was low is ignored
        e = exp_obs(1'b1, 8'h00, '0, 8'h00, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL zw_first_req got=%h want=%h", obs, e);
        end
        for (int k = 0; k < 260; k++) begin
            kk = k[PC_W-1:0];
            step();
            e = exp_obs(1'b1, kk + 8'd1, tag(kk), kk + 8'd1, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL zw_stream k=%0d got=%h want=%h", k, obs, e);
            end
        end
        imem_ack = 1'b0;
    endtask

    // ------------------------------------------------- two-cycle ack latency
    task automatic test_wait2();
        logic [OBS_W-1:0]   e;
        logic [INSTR_W-1:0] prev_i;
        logic [PC_W-1:0]    prev_p;
        logic [PC_W-1:0]    a;
        do_reset();
        step();
        prev_i = '0;
        prev_p = '0;
        for (int i = 0; i < 4; i++) begin
            a = i[PC_W-1:0];
            for (int w = 0; w < 2; w++) begin
                imem_ack = 1'b0;
                step();
                e = exp_obs(1'b1, a, prev_i, prev_p, 1'b1);
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL wait2_pending i=%0d w=%0d got=%h want=%h", i, w, obs, e);
                end
            end
            imem_ack = 1'b1;
            step();
            prev_i = tag(a);
            prev_p = a + 8'd1;
            e = exp_obs(1'b1, a + 8'd1, prev_i, prev_p, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL wait2_deliver i=%0d got=%h want=%h", i, obs, e);
            end
        end
        imem_ack = 1'b0;
    endtask

    // ------------------------------------------------------ stall into skid
    task automatic test_stall();
        logic [OBS_W-1:0] e;
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 6; k++) step();  // tag0..tag4 delivered, addr 5 pending
        stall_f = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({imem_req, instr_f, increPC_f, nop_D} !== {1'b0, tag(8'h04), 8'h05, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d got=%h want=%h", c,
                         {imem_req, instr_f, increPC_f, nop_D}, {1'b0, tag(8'h04), 8'h05, 1'b0});
            end
        end
        stall_f = 1'b0;
        step();
        e = exp_obs(1'b1, 8'h06, tag(8'h05), 8'h06, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL stall_release got=%h want=%h", obs, e);
        end
        step();
        e = exp_obs(1'b1, 8'h07, tag(8'h06), 8'h07, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL stall_next got=%h want=%h", obs, e);
        end
        imem_ack = 1'b0;
    endtask

    // ----------------------------------------- redirect with pending request
    task automatic test_redirect_flush();
        logic [OBS_W-1:0] e;
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 8; k++) step();  // tag0..tag6 delivered, addr 7 pending
        imem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        step();
        e = exp_obs(1'b1, 8'h07, tag(8'h06), 8'h07, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL flush_enter got=%h want=%h", obs, e);
        end
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL flush_wait got=%h want=%h", obs, e);
        end
        imem_ack = 1'b1;  // stale 0x07 data returns and is dropped
        step();
        e = exp_obs(1'b1, 8'h40, tag(8'h06), 8'h07, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL flush_discard got=%h want=%h", obs, e);
        end
        imem_ack = 1'b0;
        step();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL flush_target_wait got=%h want=%h", obs, e);
        end
        imem_ack = 1'b1;
        step();
        e = exp_obs(1'b1, 8'h41, tag(8'h40), 8'h41, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL flush_target got=%h want=%h", obs, e);
        end
        imem_ack = 1'b0;
    endtask

    // ------------------------- redirect while HELD, and redirect beats stall
    task automatic test_redirect_held();
        logic [OBS_W-1:0] e;
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) step();  // tag0, tag1 delivered, addr 2 pending
        stall_f = 1'b1;
        step();                                // tag2 into skid
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        step();
        e = exp_obs(1'b1, 8'h80, tag(8'h01), 8'h02, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL held_redirect got=%h want=%h", obs, e);
        end
        redirect_valid = 1'b0;
        stall_f = 1'b0;
        step();
        e = exp_obs(1'b1, 8'h81, tag(8'h80), 8'h81, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL held_target got=%h want=%h", obs, e);
        end
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        stall_f = 1'b1;
        step();
        e = exp_obs(1'b1, 8'h10, tag(8'h80), 8'h81, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL redirect_over_stall got=%h want=%h", obs, e);
        end
        redirect_valid = 1'b0;
        stall_f = 1'b0;
        step();
        e = exp_obs(1'b1, 8'h11, tag(8'h10), 8'h11, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL redirect_ack_target got=%h want=%h", obs, e);
        end
        imem_ack = 1'b0;
    endtask

    // ------------------------------------------------- async reset mid-request
    task automatic test_async_reset();
        logic [OBS_W-1:0] e;
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) step();  // tag0, tag1 delivered
        imem_ack = 1'b0;
        step();                                // addr 2 pending, bubble
        #2;
        rst = 1'b1;
        #1;
        e = exp_obs(1'b0, 8'h00, '0, 8'h00, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", obs, e);
        end
        step();
        rst = 1'b0;
        imem_ack = 1'b1;  // late ack: ignored until the new request is up
        step();
        e = exp_obs(1'b1, 8'h00, '0, 8'h00, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_restart_req got=%h want=%h", obs, e);
        end
        step();
        e = exp_obs(1'b1, 8'h01, tag(8'h00), 8'h01, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_restart_data got=%h want=%h", obs, e);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_redirect_flush();
        test_redirect_held();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
